div_dispatch: RTL
=================

# div_dispatch

Upstream request sequencer for the fixed-point divider. Accepts operand pairs on a valid/ready stream into a small FIFO, launches one division at a time using the divider's start/busy/valid protocol, and returns each quotient on a valid/ready result stream. Divide-by-zero is resolved locally and never launched. A watchdog recovers a hung divider through its synchronous clear.

## Interface
- `OP_W`, default 16: dividend/divisor width.
- `Q_W`, default 16: quotient width.
- `DEPTH`, default 4: request FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, default 64: maximum cycles allowed from launch to `div_valid`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` / `in_ready`, input / output, 1 bit each: request handshake.
- `in_a`, `in_b`, input, `OP_W` bits: dividend and divisor.
- `out_valid` / `out_ready`, output / input, 1 bit each: result handshake.
- `out_q`, output, `Q_W` bits: quotient.
- `out_ovf` output, 1 bit: divider overflow.
- `out_dvz` output, 1 bit: divisor was zero.
- `out_tout` output, 1 bit: divider timed out.
- `div_start` output, 1 bit: start pulse to the divider.
- `div_sclr` output, 1 bit: synchronous clear to the divider.
- `div_a`, `div_b`, output, `OP_W` bits: operands to the divider.
- `div_busy`, `div_valid`, `div_ovf`, input, 1 bit each: divider status.
- `div_q`, input, `Q_W` bits: divider quotient.

## Operation
- FIFO
  - Push when `in_valid & in_ready`. `in_ready = !full`.
  - Simultaneous push and pop when full is not allowed, because `in_ready` is low.
  - Simultaneous push and pop when empty cannot occur, because pop requires a non-empty FIFO.
  - Pointers are `log2(DEPTH)+1` bits and wrap naturally.
- FSM states: `IDLE`, `LAUNCH`, `HOLD`, `WAIT`, `EMIT`, `RECOVER`.
- `IDLE`
  - FIFO not empty and head `b==0`: pop and go to `EMIT` with `q=0`, `dvz=1`. No launch.
  - FIFO not empty and head `b!=0`: pop into the operand registers and go to `LAUNCH`.
- `LAUNCH`: `div_start=1` for exactly one cycle, then go to `HOLD`.
- `HOLD`
  - `div_start=0`.
  - Go to `WAIT` on the next cycle. The divider loads A/B on this edge, so `div_a`/`div_b` must already be stable.
- `WAIT`
  - On `div_valid`: capture `div_q` and `div_ovf`, then go to `EMIT`.
  - If the watchdog reaches `TIMEOUT` first: go to `RECOVER`.
- `RECOVER`
  - `div_sclr=1` for one cycle.
  - Go to `EMIT` with `q=0`, `tout=1`.
- `EMIT`
  - `out_valid=1`; result fields are held stable.
  - On `out_ready`: go to `IDLE`.
- `div_a`/`div_b` are driven from the operand registers and stay constant from `LAUNCH` through `WAIT`.
- Only one of `out_ovf`, `out_dvz`, `out_tout` may be set per result. All three are clear for a normal quotient.
- `div_busy` is used only for the watchdog. Its counter resets on `LAUNCH` and counts every cycle in `HOLD`/`WAIT`.
- A `div_valid` seen outside `WAIT` is ignored.

## Timing
- Reset (asynchronous, `rst_n=0`)
  - FSM goes to `IDLE`; FIFO is empty; watchdog counter is 0.
  - All outputs go to 0, including `div_start`, `div_sclr`, `out_valid`, `out_q` and the flags.
  - `in_ready` is 1 after reset.
- Reset asserted mid-operation aborts the in-flight division and discards queued requests. The divider receives no `div_sclr`; it is cleared by its own `sclr` path.
- Latency
  - Push to `IDLE` pop: 1 cycle minimum.
  - `IDLE` to `div_start`: 1 cycle.
  - `div_valid` to `out_valid`: 1 cycle.
  - Divide-by-zero, push to `out_valid`: 2 cycles.
- Back-to-back: after an `EMIT` handshake, the next launch starts no earlier than 2 cycles later (`IDLE` then `LAUNCH`).
- Outputs `out_*`, `div_start` and `div_sclr` are registered and glitch-free.

## Structure
- Shared package `div_pkg`:
  - FSM state enum `dispatch_state_t`.
  - Result struct `{q, ovf, dvz, tout}`.
  - Default `OP_W`, `Q_W`, `TIMEOUT`.
- Sub-module `div_req_fifo`: parameterized synchronous FIFO with `{a,b}` payload, `full`/`empty` outputs and async active-low reset.
- `div_dispatch` contains the FSM, operand and result registers, and the watchdog counter.

## Test plan
- Normal division
  - Stimulus: push `a=100`, `b=4`; bench divider model returns `div_valid` with `q=25` 20 cycles after start.
  - Required: exactly one `div_start` pulse, `div_a`/`div_b` stable throughout, `out_valid` with `q=25` and all flags 0.
- Divide by zero
  - Stimulus: push `a=7`, `b=0`.
  - Required: no `div_start`; `out_valid` 2 cycles later with `q=0`, `dvz=1`.
- FIFO full with backpressure
  - Stimulus: hold `out_ready=0`; push `DEPTH+1` requests.
  - Required: `in_ready` drops after the FIFO fills. After releasing `out_ready`, all results appear in order with no loss or duplication.
- Overflow
  - Stimulus: divider model asserts `div_ovf` with `div_valid`.
  - Required: `out_ovf=1`.
- Timeout
  - Stimulus: divider model never asserts `div_valid`.
  - Required: `div_sclr` pulses at `TIMEOUT`; the result has `tout=1`, `q=0`; the next queued request launches normally.
- Asynchronous reset in `WAIT`
  - Stimulus: drop `rst_n` mid-cycle.
  - Required: all outputs go to 0 immediately; FIFO is empty; a late `div_valid` after reset produces no result.

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and defaults for the divider request dispatcher.
//   dispatch_state_t : dispatcher FSM states
//   div_result_t     : one result record {q, ovf, dvz, tout}
//   DIV_OP_W / DIV_Q_W / DIV_TIMEOUT : default operand width, quotient width
//                                      and launch-to-valid cycle limit
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int unsigned DIV_OP_W    = 16;
  localparam int unsigned DIV_Q_W     = 16;
  localparam int unsigned DIV_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    HOLD,
    WAIT,
    EMIT,
    RECOVER
  } dispatch_state_t;

  // The quotient field is sized by DIV_Q_W, so a dispatcher instance must
  // keep Q_W equal to DIV_Q_W.
  typedef struct packed {
    logic [DIV_Q_W-1:0] q;
    logic               ovf;
    logic               dvz;
    logic               tout;
  } div_result_t;

  // Result records for the two locally resolved outcomes.
  localparam div_result_t RESULT_DVZ  = '{q: '0, ovf: 1'b0, dvz: 1'b1, tout: 1'b0};
  localparam div_result_t RESULT_TOUT = '{q: '0, ovf: 1'b0, dvz: 1'b0, tout: 1'b1};

endpackage

// File: rtl/div_req_fifo.sv
// ---------------------------------------------------------------------------
// div_req_fifo
// Synchronous request FIFO holding {a, b} operand pairs.
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO)
//   push_i        : write wdata_i (ignored when full)
//   pop_i         : discard the head entry (ignored when empty)
//   wdata_i       : payload in
//   rdata_o       : head entry (valid when empty_o is low)
//   full_o/empty_o: occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module div_req_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written,
  // and emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/div_dispatch.sv
// ---------------------------------------------------------------------------
// div_dispatch
// Request sequencer in front of the fixed-point divider. Queues operand
// pairs, launches one division at a time, resolves divide-by-zero locally,
// recovers a hung divider via its synchronous clear, and returns results.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : request handshake, operands in_a / in_b
//   out_valid/out_ready       : result handshake
//   out_q, out_ovf, out_dvz, out_tout : quotient and exclusive status flags
//   div_start, div_sclr       : start pulse and synchronous clear to divider
//   div_a, div_b              : operands to divider (stable LAUNCH..WAIT)
//   div_busy, div_valid, div_ovf, div_q : divider status and result
// ---------------------------------------------------------------------------
module div_dispatch
  import div_pkg::*;
#(
  parameter int unsigned OP_W    = DIV_OP_W,
  parameter int unsigned Q_W     = DIV_Q_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = DIV_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Q_W-1:0]  out_q,
  output logic            out_ovf,
  output logic            out_dvz,
  output logic            out_tout,
  output logic            div_start,
  output logic            div_sclr,
  output logic [OP_W-1:0] div_a,
  output logic [OP_W-1:0] div_b,
  input  logic            div_busy,
  input  logic            div_valid,
  input  logic            div_ovf,
  input  logic [Q_W-1:0]  div_q
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // ---------------- request FIFO ----------------
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [2*OP_W-1:0] fifo_rdata;
  logic [OP_W-1:0]   head_a;
  logic [OP_W-1:0]   head_b;

  assign in_ready = !fifo_full;
  assign head_a   = fifo_rdata[2*OP_W-1:OP_W];
  assign head_b   = fifo_rdata[OP_W-1:0];

  div_req_fifo #(
    .W     (2 * OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .pop_i   (fifo_pop),
    .wdata_i ({in_a, in_b}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- state ----------------
  dispatch_state_t state_q, state_d;
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  div_result_t     res_q, res_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            div_start_q;
  logic            div_sclr_q;
  logic            out_valid_q;

  // The watchdog runs off the FSM alone, so a divider that drops busy but
  // never raises valid is still caught; busy carries no extra information.
  logic unused_div_busy;
  assign unused_div_busy = div_busy;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    wdog_d   = wdog_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_b == '0) begin
            res_d   = RESULT_DVZ;
            state_d = EMIT;
          end else begin
            a_d     = head_a;
            b_d     = head_b;
            state_d = LAUNCH;
          end
        end
      end

      LAUNCH: begin
        wdog_d  = '0;
        state_d = HOLD;
      end

      // The divider loads div_a/div_b on the edge leaving this state.
      HOLD: begin
        wdog_d  = wdog_q + WD_ONE;
        state_d = WAIT;
      end

      // In WAIT cycle k after launch the counter holds k-1, so the last
      // accepted div_valid is exactly TIMEOUT cycles after the start pulse.
      WAIT: begin
        wdog_d = wdog_q + WD_ONE;
        if (div_valid) begin
          res_d   = '{q: div_q, ovf: div_ovf, dvz: 1'b0, tout: 1'b0};
          state_d = EMIT;
        end else if (wdog_q == WD_LAST) begin
          state_d = RECOVER;
        end
      end

      RECOVER: begin
        res_d   = RESULT_TOUT;
        state_d = EMIT;
      end

      EMIT: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobe outputs are decoded from the next state so they leave flops and
  // line up with the cycle spent in the corresponding state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      wdog_q      <= '0;
      div_start_q <= 1'b0;
      div_sclr_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      wdog_q      <= wdog_d;
      div_start_q <= (state_d == LAUNCH);
      div_sclr_q  <= (state_d == RECOVER);
      out_valid_q <= (state_d == EMIT);
    end
  end

  assign div_start = div_start_q;
  assign div_sclr  = div_sclr_q;
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign out_valid = out_valid_q;
  assign out_q     = res_q.q;
  assign out_ovf   = res_q.ovf;
  assign out_dvz   = res_q.dvz;
  assign out_tout  = res_q.tout;

endmodule
